// File: rtl/cpu_exec_ctrl_pkg.sv
// Shared types for the CPU run controller: FSM states, host command opcodes
// and halt-cause codes.
package cpu_exec_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CPURST = 3'd2,
    S_RUN    = 3'd3,
    S_HALTED = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_RUN  = 2'd1,
    OP_STEP = 2'd2,
    OP_HALT = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    HC_NONE     = 2'd0,
    HC_HALT_CMD = 2'd1,
    HC_COUNT    = 2'd2,
    HC_BRK      = 2'd3
  } halt_cause_e;

  // LOAD, RUN and STEP all start new work; only HALT is harmless while running.
  function automatic logic is_start_op(input cmd_op_e op);
    return op != OP_HALT;
  endfunction

endpackage

// File: rtl/cpu_exec_ctrl_if.sv
// Host-side command and program-load channels of the run controller, both
// valid/ready handshakes. master = host/debug side, slave = controller side.
interface cpu_exec_ctrl_if #(
  parameter int CNT_W = 32
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_arg;

  logic             load_valid;
  logic             load_ready;
  logic [31:0]      load_data;
  logic             load_last;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, load_valid, load_data, load_last,
    input  cmd_ready, load_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, load_valid, load_data, load_last,
    output cmd_ready, load_ready
  );

endinterface

// File: rtl/cpu_exec_ctrl.sv
// Run controller for the single-cycle CPU: streams a program into imem, pulses
// the CPU reset, then gates global_en for free-run, N-cycle, step or breakpoint.
module cpu_exec_ctrl
  import cpu_exec_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  cpu_exec_ctrl_if.slave    host,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_d,
  output logic              cpu_rst,
  output logic              cpu_en,
  input  logic [31:0]       cpu_pc,
  input  logic              brk_en,
  input  logic [31:0]       brk_pc,
  output logic [2:0]        state,
  output logic [1:0]        halt_cause,
  output logic              done,
  output logic              cmd_err,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_e            state_q, state_d;
  halt_cause_e       halt_cause_q, halt_cause_d;
  logic              init_q, init_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic              done_q, done_d;
  logic              cmd_err_q, cmd_err_d;

  cmd_op_e op;
  logic    cmd_acc;
  logic    word_acc;
  logic    brk_hit;

  // init_q holds cmd_ready low and cpu_rst high for the first cycle after reset.
  assign host.cmd_ready  = init_q &&
                           (state_q == S_IDLE || state_q == S_HALTED || state_q == S_RUN);
  assign host.load_ready = (state_q == S_LOAD);

  assign op       = cmd_op_e'(host.cmd_op);
  assign cmd_acc  = host.cmd_valid & host.cmd_ready;
  assign word_acc = host.load_valid & host.load_ready;
  assign brk_hit  = brk_en & (cpu_pc == brk_pc);

  assign mem_we     = word_acc;
  assign mem_a      = mem_a_q;
  assign mem_d      = word_acc ? host.load_data : 32'd0;
  assign cpu_rst    = ~init_q | (state_q == S_CPURST);
  // A breakpoint hit suppresses the enable in the same cycle, so brk_pc never executes.
  assign cpu_en     = (state_q == S_RUN) & ~brk_hit;
  assign state      = state_q;
  assign halt_cause = halt_cause_q;
  assign done       = done_q;
  assign cmd_err    = cmd_err_q;
  assign cycle_cnt  = cycle_cnt_q;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    halt_cause_d = halt_cause_q;
    init_d       = 1'b1;
    mem_a_d      = mem_a_q;
    remaining_d  = remaining_q;
    cycle_cnt_d  = cycle_cnt_q;
    rst_cnt_d    = rst_cnt_q;
    cmd_err_d    = 1'b0;

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (cmd_acc && is_start_op(op)) halt_cause_d = HC_NONE;
        if (cmd_acc) begin
          case (op)
            OP_LOAD: begin
              state_d = S_LOAD;
              mem_a_d = host.cmd_arg[ADDR_W-1:0];
            end
            OP_RUN: begin
              state_d     = S_RUN;
              remaining_d = host.cmd_arg;
            end
            OP_STEP: begin
              state_d     = S_RUN;
              remaining_d = CNT_W'(1);
            end
            default: ;
          endcase
        end
      end

      S_LOAD: begin
        if (word_acc) begin
          mem_a_d = mem_a_q + ADDR_W'(1);
          if (host.load_last) begin
            state_d     = S_CPURST;
            rst_cnt_d   = RC_W'(RST_CYCLES - 1);
            cycle_cnt_d = '0;
          end
        end
      end

      S_CPURST: begin
        if (rst_cnt_q == '0) state_d = S_IDLE;
        else                 rst_cnt_d = rst_cnt_q - RC_W'(1);
      end

      S_RUN: begin
        if (cpu_en) begin
          if (cycle_cnt_q != '1)   cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
          if (remaining_q != '0)   remaining_d = remaining_q - CNT_W'(1);
        end
        // remaining only reaches 1 from a nonzero RUN/STEP argument; 0 means unbounded.
        if (brk_hit) begin
          state_d      = S_HALTED;
          halt_cause_d = HC_BRK;
        end else if (remaining_q == CNT_W'(1)) begin
          state_d      = S_HALTED;
          halt_cause_d = HC_COUNT;
        end else if (cmd_acc && op == OP_HALT) begin
          state_d      = S_HALTED;
          halt_cause_d = HC_HALT_CMD;
        end
        if (cmd_acc && is_start_op(op)) cmd_err_d = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_HALTED) && (state_q != S_HALTED);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      halt_cause_q <= HC_NONE;
      init_q       <= 1'b0;
      mem_a_q      <= '0;
      remaining_q  <= '0;
      cycle_cnt_q  <= '0;
      rst_cnt_q    <= '0;
      done_q       <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      halt_cause_q <= halt_cause_d;
      init_q       <= init_d;
      mem_a_q      <= mem_a_d;
      remaining_q  <= remaining_d;
      cycle_cnt_q  <= cycle_cnt_d;
      rst_cnt_q    <= rst_cnt_d;
      done_q       <= done_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Directed bench for cpu_exec_ctrl: a per-cycle vector table for the basic load
// and CPU-reset sequence, plus hand-written run/step/breakpoint/reset sequences.
module tb_cpu_exec_ctrl;

  localparam int ADDR_W = 10;
  localparam int CNT_W  = 32;
  localparam logic [31:0] PC_BASE = 32'h0040_0000;
  localparam logic [31:0] BRK_PC  = 32'h0040_000C;

  logic              clk;
  logic              rst;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [31:0]       mem_d;
  logic              cpu_rst;
  logic              cpu_en;
  logic [31:0]       cpu_pc;
  logic              brk_en;
  logic [31:0]       brk_pc;
  logic [2:0]        state;
  logic [1:0]        halt_cause;
  logic              done;
  logic              cmd_err;
  logic [CNT_W-1:0]  cycle_cnt;

  int total = 0;
  int bad   = 0;

  cpu_exec_ctrl_if #(.CNT_W(CNT_W)) host_if ();

  cpu_exec_ctrl #(.ADDR_W(ADDR_W), .RST_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .host       (host_if),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_d      (mem_d),
    .cpu_rst    (cpu_rst),
    .cpu_en     (cpu_en),
    .cpu_pc     (cpu_pc),
    .brk_en     (brk_en),
    .brk_pc     (brk_pc),
    .state      (state),
    .halt_cause (halt_cause),
    .done       (done),
    .cmd_err    (cmd_err),
    .cycle_cnt  (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in CPU: PC resets to the text base and advances one word per enabled cycle.
  always @(posedge clk) begin
    if (cpu_rst)     cpu_pc <= PC_BASE;
    else if (cpu_en) cpu_pc <= cpu_pc + 32'd4;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [31:0] arg);
    host_if.cmd_valid = 1'b1;
    host_if.cmd_op    = op;
    host_if.cmd_arg   = arg;
    step();
    host_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (state != 3'd0 && n < 20) begin
      step();
      n++;
    end
    check(name, {29'd0, state}, 32'd0);
  endtask

  typedef struct {
    logic        cv;
    logic [1:0]  op;
    logic [31:0] arg;
    logic        lv;
    logic [31:0] ld;
    logic        ll;
    logic [2:0]  e_state;
    logic        e_we;
    logic [9:0]  e_a;
    logic [31:0] e_d;
    logic        e_rst;
    logic        e_rdy;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [9:0] wrap_a [4];
    int en_cnt;
    int done_cnt;
    int we_cnt;
    int n;

    //            cv    op    arg    lv    ld            ll    st    we    a      d             rst   rdy
    tbl[0]  = '{1'b1, 2'd0, 32'd0, 1'b0, 32'h0,        1'b0, 3'd0, 1'b0, 10'd0, 32'h0,        1'b0, 1'b1};
    tbl[1]  = '{1'b0, 2'd0, 32'd0, 1'b1, 32'hA000_0001, 1'b0, 3'd1, 1'b1, 10'd0, 32'hA000_0001, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 2'd0, 32'd0, 1'b1, 32'hA000_0002, 1'b0, 3'd1, 1'b1, 10'd1, 32'hA000_0002, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 32'd0, 1'b0, 32'hDEAD_BEEF, 1'b0, 3'd1, 1'b0, 10'd2, 32'h0,        1'b0, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 32'd0, 1'b1, 32'hA000_0003, 1'b0, 3'd1, 1'b1, 10'd2, 32'hA000_0003, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, 32'd0, 1'b1, 32'hA000_0004, 1'b1, 3'd1, 1'b1, 10'd3, 32'hA000_0004, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 2'd0, 32'd0, 1'b0, 32'h0,        1'b0, 3'd2, 1'b0, 10'd4, 32'h0,        1'b1, 1'b0};
    tbl[7]  = '{1'b0, 2'd0, 32'd0, 1'b0, 32'h0,        1'b0, 3'd2, 1'b0, 10'd4, 32'h0,        1'b1, 1'b0};
    tbl[8]  = '{1'b0, 2'd0, 32'd0, 1'b0, 32'h0,        1'b0, 3'd2, 1'b0, 10'd4, 32'h0,        1'b1, 1'b0};
    tbl[9]  = '{1'b0, 2'd0, 32'd0, 1'b0, 32'h0,        1'b0, 3'd2, 1'b0, 10'd4, 32'h0,        1'b1, 1'b0};
    tbl[10] = '{1'b0, 2'd0, 32'd0, 1'b0, 32'h0,        1'b0, 3'd0, 1'b0, 10'd4, 32'h0,        1'b0, 1'b1};

    wrap_a = '{10'd1022, 10'd1023, 10'd0, 10'd1};

    rst                = 1'b0;
    host_if.cmd_valid  = 1'b0;
    host_if.cmd_op     = 2'd0;
    host_if.cmd_arg    = '0;
    host_if.load_valid = 1'b0;
    host_if.load_data  = '0;
    host_if.load_last  = 1'b0;
    brk_en             = 1'b0;
    brk_pc             = BRK_PC;

    // Reset state
    repeat (3) step();
    check("rst_state",      {29'd0, state}, 32'd0);
    check("rst_mem_we",     {31'd0, mem_we}, 32'd0);
    check("rst_mem_a",      {22'd0, mem_a}, 32'd0);
    check("rst_mem_d",      mem_d, 32'd0);
    check("rst_cpu_rst",    {31'd0, cpu_rst}, 32'd1);
    check("rst_cpu_en",     {31'd0, cpu_en}, 32'd0);
    check("rst_cmd_ready",  {31'd0, host_if.cmd_ready}, 32'd0);
    check("rst_load_ready", {31'd0, host_if.load_ready}, 32'd0);
    check("rst_halt_cause", {30'd0, halt_cause}, 32'd0);
    check("rst_done",       {31'd0, done}, 32'd0);
    check("rst_cmd_err",    {31'd0, cmd_err}, 32'd0);
    check("rst_cycle_cnt",  cycle_cnt, 32'd0);
    rst = 1'b1;
    step();
    check("rel_cpu_rst",   {31'd0, cpu_rst}, 32'd0);
    check("rel_cmd_ready", {31'd0, host_if.cmd_ready}, 32'd1);

    // Table: LOAD 4 words from address 0, then the 4-cycle CPU reset
    for (int i = 0; i < 11; i++) begin
      host_if.cmd_valid  = tbl[i].cv;
      host_if.cmd_op     = tbl[i].op;
      host_if.cmd_arg    = tbl[i].arg;
      host_if.load_valid = tbl[i].lv;
      host_if.load_data  = tbl[i].ld;
      host_if.load_last  = tbl[i].ll;
      #1;
      check($sformatf("tbl%0d_state", i),   {29'd0, state}, {29'd0, tbl[i].e_state});
      check($sformatf("tbl%0d_we", i),      {31'd0, mem_we}, {31'd0, tbl[i].e_we});
      check($sformatf("tbl%0d_a", i),       {22'd0, mem_a}, {22'd0, tbl[i].e_a});
      check($sformatf("tbl%0d_d", i),       mem_d, tbl[i].e_d);
      check($sformatf("tbl%0d_cpu_rst", i), {31'd0, cpu_rst}, {31'd0, tbl[i].e_rst});
      check($sformatf("tbl%0d_ready", i),   {31'd0, host_if.cmd_ready}, {31'd0, tbl[i].e_rdy});
      check($sformatf("tbl%0d_cpu_en", i),  {31'd0, cpu_en}, 32'd0);
      step();
    end
    host_if.cmd_valid  = 1'b0;
    host_if.load_valid = 1'b0;
    host_if.load_last  = 1'b0;

    // LOAD at 1022 wraps the word address
    send_cmd(2'd0, 32'd1022);
    for (int i = 0; i < 4; i++) begin
      host_if.load_valid = 1'b1;
      host_if.load_data  = 32'h100 + i;
      host_if.load_last  = (i == 3);
      #1;
      check($sformatf("wrap%0d_we", i), {31'd0, mem_we}, 32'd1);
      check($sformatf("wrap%0d_a", i),  {22'd0, mem_a}, {22'd0, wrap_a[i]});
      step();
    end
    host_if.load_valid = 1'b0;
    host_if.load_last  = 1'b0;
    wait_idle("wrap_back_idle");

    // RUN 5: exactly 5 enabled cycles, one done pulse, count-expired cause
    send_cmd(2'd1, 32'd5);
    check("run5_state", {29'd0, state}, 32'd3);
    en_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (cpu_en) en_cnt++;
      if (done) done_cnt++;
      step();
    end
    check("run5_en_cycles",  en_cnt, 32'd5);
    check("run5_done_count", done_cnt, 32'd1);
    check("run5_cause",      {30'd0, halt_cause}, 32'd2);
    check("run5_cycle_cnt",  cycle_cnt, 32'd5);
    check("run5_halted",     {29'd0, state}, 32'd4);

    // Single-word load clears cycle_cnt, then STEP x3
    send_cmd(2'd0, 32'd16);
    check("load_clears_cause", {30'd0, halt_cause}, 32'd0);
    host_if.load_valid = 1'b1;
    host_if.load_last  = 1'b1;
    host_if.load_data  = 32'h0000_0013;
    step();
    host_if.load_valid = 1'b0;
    host_if.load_last  = 1'b0;
    wait_idle("step_load_idle");
    check("step_cnt_cleared", cycle_cnt, 32'd0);
    for (int k = 0; k < 3; k++) begin
      send_cmd(2'd2, 32'd0);
      en_cnt = 0;
      done_cnt = 0;
      for (int c = 0; c < 6; c++) begin
        if (cpu_en) en_cnt++;
        if (done) done_cnt++;
        step();
      end
      check($sformatf("step%0d_en", k),   en_cnt, 32'd1);
      check($sformatf("step%0d_done", k), done_cnt, 32'd1);
    end
    check("step_cycle_cnt", cycle_cnt, 32'd3);
    check("step_cause",     {30'd0, halt_cause}, 32'd2);

    // Breakpoint at 0x0040000C with a HALT offered in the hit cycle
    send_cmd(2'd0, 32'd0);
    host_if.load_valid = 1'b1;
    host_if.load_last  = 1'b1;
    step();
    host_if.load_valid = 1'b0;
    host_if.load_last  = 1'b0;
    wait_idle("brk_load_idle");
    check("brk_pc_reset", cpu_pc, PC_BASE);
    brk_en = 1'b1;
    send_cmd(2'd1, 32'd0);
    en_cnt = 0;
    n = 0;
    while (cpu_pc != BRK_PC && n < 20) begin
      if (cpu_en) en_cnt++;
      step();
      n++;
    end
    check("brk_pc_reached", cpu_pc, BRK_PC);
    check("brk_en_low",     {31'd0, cpu_en}, 32'd0);
    check("brk_still_run",  {29'd0, state}, 32'd3);
    send_cmd(2'd3, 32'd0);
    check("brk_halted",    {29'd0, state}, 32'd4);
    check("brk_cause",     {30'd0, halt_cause}, 32'd3);
    check("brk_done",      {31'd0, done}, 32'd1);
    check("brk_no_err",    {31'd0, cmd_err}, 32'd0);
    check("brk_en_cycles", en_cnt, 32'd3);
    check("brk_cycle_cnt", cycle_cnt, 32'd3);
    check("brk_pc_held",   cpu_pc, BRK_PC);
    brk_en = 1'b0;

    // Reset during the second load word
    send_cmd(2'd0, 32'd0);
    host_if.load_valid = 1'b1;
    host_if.load_data  = 32'h1111_1111;
    step();
    host_if.load_data  = 32'h2222_2222;
    #1;
    check("midrst_we_before", {31'd0, mem_we}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_we",         {31'd0, mem_we}, 32'd0);
    check("midrst_cpu_rst",    {31'd0, cpu_rst}, 32'd1);
    check("midrst_state",      {29'd0, state}, 32'd0);
    check("midrst_load_ready", {31'd0, host_if.load_ready}, 32'd0);
    we_cnt = 0;
    step();
    for (int c = 0; c < 4; c++) begin
      if (c == 2) rst = 1'b1;
      if (mem_we) we_cnt++;
      step();
    end
    host_if.load_valid = 1'b0;
    check("midrst_no_writes", we_cnt, 32'd0);
    check("midrst_ready",     {31'd0, host_if.cmd_ready}, 32'd1);
    check("midrst_cycle_cnt", cycle_cnt, 32'd0);

    // LOAD offered while running: cmd_err pulse, RUN continues; then HALT
    send_cmd(2'd1, 32'd0);
    check("err_run_state", {29'd0, state}, 32'd3);
    send_cmd(2'd0, 32'd5);
    check("err_pulse",     {31'd0, cmd_err}, 32'd1);
    check("err_state",     {29'd0, state}, 32'd3);
    check("err_cpu_en",    {31'd0, cpu_en}, 32'd1);
    step();
    check("err_pulse_end", {31'd0, cmd_err}, 32'd0);
    check("err_still_run", {29'd0, state}, 32'd3);
    send_cmd(2'd3, 32'd0);
    check("halt_state", {29'd0, state}, 32'd4);
    check("halt_cause", {30'd0, halt_cause}, 32'd1);
    check("halt_done",  {31'd0, done}, 32'd1);
    step();
    check("halt_done_end", {31'd0, done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
